// File: rtl/keypad_scanner_if.sv
// Signal bundle between the 4x4 keypad scanner and its surroundings.
// The master side is the scanner; the slave side is the keypad plus display consumer.
interface keypad_scanner_if;
   logic [3:0]  Col;
   logic [3:0]  Row;
   logic [3:0]  KeyCode;
   logic        KeyValid;
   logic        KeyHeld;
   logic [15:0] Value;

   modport master (
      input  Col,
      output Row,
      output KeyCode,
      output KeyValid,
      output KeyHeld,
      output Value
   );

   modport slave (
      output Col,
      input  Row,
      input  KeyCode,
      input  KeyValid,
      input  KeyHeld,
      input  Value
   );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one-cold row scan, debounced single-key capture,
// release debounce, and a 4-digit hex shift register of accepted keys.
module keypad_scanner #(
   parameter int SCAN_DIV     = 1000,
   parameter int DEBOUNCE_CNT = 20000
) (
   input logic              Clk,
   input logic              Rst,
   keypad_scanner_if.master kp
);

   localparam int DW = $clog2(SCAN_DIV);
   localparam int CW = $clog2(DEBOUNCE_CNT);
   localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CNT - 1);

   typedef enum logic [1:0] {
      SCAN,
      DEBOUNCE,
      HELD
   } state_t;

   state_t        state, state_nxt;
   logic [3:0]    col_meta, col_s;
   logic [1:0]    row_idx, row_idx_nxt;
   logic [DW-1:0] dwell, dwell_nxt;
   logic [CW-1:0] deb, deb_nxt;
   logic [3:0]    cap_col, cap_col_nxt;
   logic [1:0]    cap_c, cap_c_nxt;
   logic [3:0]    row_q, row_nxt;
   logic [3:0]    key_code, key_code_nxt;
   logic          key_valid, key_valid_nxt;
   logic          key_held, key_held_nxt;
   logic [15:0]   value, value_nxt;
   logic          single_low;
   logic [1:0]    low_idx;
   logic [3:0]    mapped_key;

   function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] k;
      case ({r, c})
         4'h0: k = 4'h1;
         4'h1: k = 4'h2;
         4'h2: k = 4'h3;
         4'h3: k = 4'hA;
         4'h4: k = 4'h4;
         4'h5: k = 4'h5;
         4'h6: k = 4'h6;
         4'h7: k = 4'hB;
         4'h8: k = 4'h7;
         4'h9: k = 4'h8;
         4'hA: k = 4'h9;
         4'hB: k = 4'hC;
         4'hC: k = 4'h0;
         4'hD: k = 4'hF;
         4'hE: k = 4'hE;
         default: k = 4'hD;
      endcase
      return k;
   endfunction

   // Columns are asynchronous to Clk; only the second flop is ever looked at.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         col_meta <= 4'hF;
         col_s    <= 4'hF;
      end else begin
         col_meta <= kp.Col;
         col_s    <= col_meta;
      end
   end

   always_comb begin
      single_low = 1'b1;
      low_idx    = 2'd0;
      case (col_s)
         4'b1110: low_idx = 2'd0;
         4'b1101: low_idx = 2'd1;
         4'b1011: low_idx = 2'd2;
         4'b0111: low_idx = 2'd3;
         default: single_low = 1'b0;
      endcase
   end

   assign mapped_key = key_map(row_idx, cap_c);

   always_comb begin
      state_nxt     = state;
      row_idx_nxt   = row_idx;
      dwell_nxt     = dwell;
      deb_nxt       = deb;
      cap_col_nxt   = cap_col;
      cap_c_nxt     = cap_c;
      key_code_nxt  = key_code;
      key_valid_nxt = 1'b0;
      key_held_nxt  = key_held;
      value_nxt     = value;

      unique case (state)
         SCAN: begin
            if (dwell == DWELL_LAST) begin
               dwell_nxt = '0;
               // Zero or several low columns means no key or a possible ghost.
               if (single_low) begin
                  cap_col_nxt = col_s;
                  cap_c_nxt   = low_idx;
                  deb_nxt     = '0;
                  state_nxt   = DEBOUNCE;
               end else begin
                  row_idx_nxt = row_idx + 2'd1;
               end
            end else begin
               dwell_nxt = dwell + DW'(1);
            end
         end

         DEBOUNCE: begin
            if (col_s == cap_col) begin
               if (deb == DEB_LAST) begin
                  deb_nxt       = '0;
                  state_nxt     = HELD;
                  key_code_nxt  = mapped_key;
                  key_valid_nxt = 1'b1;
                  key_held_nxt  = 1'b1;
                  value_nxt     = {value[11:0], mapped_key};
               end else begin
                  deb_nxt = deb + CW'(1);
               end
            end else begin
               state_nxt   = SCAN;
               row_idx_nxt = row_idx + 2'd1;
               dwell_nxt   = '0;
            end
         end

         HELD: begin
            // Only an all-high column bus counts toward release; other changes are ignored.
            if (col_s == 4'hF) begin
               if (deb == DEB_LAST) begin
                  deb_nxt      = '0;
                  key_held_nxt = 1'b0;
                  state_nxt    = SCAN;
                  row_idx_nxt  = row_idx + 2'd1;
                  dwell_nxt    = '0;
               end else begin
                  deb_nxt = deb + CW'(1);
               end
            end else begin
               deb_nxt = '0;
            end
         end

         default: begin
            state_nxt = SCAN;
         end
      endcase

      row_nxt = ~(4'b0001 << row_idx_nxt);
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state     <= SCAN;
         row_idx   <= 2'd0;
         dwell     <= '0;
         deb       <= '0;
         cap_col   <= 4'hF;
         cap_c     <= 2'd0;
         row_q     <= 4'b1110;
         key_code  <= 4'h0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
         value     <= 16'h0000;
      end else begin
         state     <= state_nxt;
         row_idx   <= row_idx_nxt;
         dwell     <= dwell_nxt;
         deb       <= deb_nxt;
         cap_col   <= cap_col_nxt;
         cap_c     <= cap_c_nxt;
         row_q     <= row_nxt;
         key_code  <= key_code_nxt;
         key_valid <= key_valid_nxt;
         key_held  <= key_held_nxt;
         value     <= value_nxt;
      end
   end

   assign kp.Row      = row_q;
   assign kp.KeyCode  = key_code;
   assign kp.KeyValid = key_valid;
   assign kp.KeyHeld  = key_held;
   assign kp.Value    = value;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CNT=8 and a behavioural keypad matrix.
// Expected key results are queued when a press is driven and checked when KeyValid fires.
module tb_keypad_scanner;

   localparam int SCAN_DIV     = 4;
   localparam int DEBOUNCE_CNT = 8;
   localparam int PRESS_BUDGET = 2 + 4 * SCAN_DIV + DEBOUNCE_CNT;

   typedef struct {
      logic        do_rst;
      logic [3:0]  row;
      logic [3:0]  cols;
      logic        bounce;
      logic [3:0]  exp_code;
      logic [15:0] exp_value;
   } vec_t;

   typedef struct packed {
      logic [3:0]  code;
      logic [15:0] value;
   } exp_t;

   logic Clk;
   logic Rst;
   logic press_active;
   logic press_open;
   logic [3:0] press_row;
   logic [3:0] press_cols;

   int n_vectors;
   int n_miscompares;
   int n_pulses;
   int n_pushed;
   exp_t exp_q[$];
   exp_t mon_e;
   vec_t vecs[9];
   logic [3:0] row_seq[4];

   keypad_scanner_if kif ();

   keypad_scanner #(
      .SCAN_DIV    (SCAN_DIV),
      .DEBOUNCE_CNT(DEBOUNCE_CNT)
   ) dut (
      .Clk(Clk),
      .Rst(Rst),
      .kp (kif.master)
   );

   // A pressed key pulls its column low only while its own row is driven.
   assign kif.Col = (press_active && !press_open && kif.Row == press_row) ? press_cols : 4'hF;

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      n_vectors++;
      if (actual !== expected) begin
         n_miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   always @(negedge Clk) begin
      if (kif.KeyValid === 1'b1) begin
         n_pulses++;
         if (exp_q.size() == 0) begin
            checkOutput("spurious_keyvalid", 16'(kif.KeyValid), 16'd0);
         end else begin
            mon_e = exp_q.pop_front();
            checkOutput("keycode", 16'(kif.KeyCode), 16'(mon_e.code));
            checkOutput("value", kif.Value, mon_e.value);
            checkOutput("keyheld_at_accept", 16'(kif.KeyHeld), 16'd1);
         end
      end
   end

   task automatic doReset();
      @(negedge Clk);
      Rst          = 1'b1;
      press_active = 1'b0;
      @(negedge Clk);
      Rst = 1'b0;
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_row"}, 16'(kif.Row), 16'h000E);
      checkOutput({tag, "_keycode"}, 16'(kif.KeyCode), 16'h0000);
      checkOutput({tag, "_keyvalid"}, 16'(kif.KeyValid), 16'h0000);
      checkOutput({tag, "_keyheld"}, 16'(kif.KeyHeld), 16'h0000);
      checkOutput({tag, "_value"}, kif.Value, 16'h0000);
   endtask

   task automatic pressKey(input logic [3:0] row, input logic [3:0] cols, input logic bounce,
                           input logic [3:0] code, input logic [15:0] value, output logic found);
      int quiet_bad;
      int budget;
      exp_t e;
      e.code  = code;
      e.value = value;
      exp_q.push_back(e);
      n_pushed++;
      press_row    = row;
      press_cols   = cols;
      press_open   = 1'b0;
      press_active = 1'b1;
      budget       = bounce ? 3 * PRESS_BUDGET : PRESS_BUDGET;
      if (bounce) begin
         quiet_bad = 0;
         for (int i = 0; i < 20; i++) begin
            press_open = ((i / 3) % 2) == 1;
            @(negedge Clk);
            if (kif.KeyValid === 1'b1) quiet_bad++;
         end
         press_open = 1'b0;
         checkOutput("bounce_quiet", 16'(quiet_bad), 16'd0);
      end
      found = 1'b0;
      for (int c = 1; c <= budget && !found; c++) begin
         @(negedge Clk);
         if (kif.KeyValid === 1'b1) found = 1'b1;
      end
      checkOutput($sformatf("press_%h_accepted", code), 16'(found), 16'd1);
   endtask

   task automatic applyStimulus(input vec_t v);
      logic found;
      int bad;
      if (v.do_rst) doReset();
      pressKey(v.row, v.cols, v.bounce, v.exp_code, v.exp_value, found);
      if (found) begin
         bad = 0;
         for (int i = 0; i < 12; i++) begin
            // Sliding to a neighbouring column mid-hold must not disturb the held key.
            press_cols = (i >= 4 && i < 8) ? {v.cols[2:0], v.cols[3]} : v.cols;
            @(negedge Clk);
            if (kif.KeyHeld !== 1'b1 || kif.Row !== v.row) bad++;
         end
         press_cols = v.cols;
         checkOutput("hold_steady", 16'(bad), 16'd0);
         press_active = 1'b0;
         repeat (DEBOUNCE_CNT + 1) @(negedge Clk);
         checkOutput("held_until_release_debounced", 16'(kif.KeyHeld), 16'd1);
         @(negedge Clk);
         checkOutput("held_drop", 16'(kif.KeyHeld), 16'd0);
      end
      press_active = 1'b0;
      repeat (4) @(negedge Clk);
   endtask

   initial begin
      logic found;
      logic [3:0] seen;
      logic [3:0] prev_row;
      n_vectors     = 0;
      n_miscompares = 0;
      n_pulses      = 0;
      n_pushed      = 0;
      Rst           = 1'b0;
      press_active  = 1'b0;
      press_open    = 1'b0;
      press_row     = 4'hF;
      press_cols    = 4'hF;
      row_seq[0] = 4'hE;
      row_seq[1] = 4'hD;
      row_seq[2] = 4'hB;
      row_seq[3] = 4'h7;

      vecs[0] = '{1'b1, 4'b1101, 4'b1101, 1'b0, 4'h5, 16'h0005};
      vecs[1] = '{1'b1, 4'b1110, 4'b1110, 1'b0, 4'h1, 16'h0001};
      vecs[2] = '{1'b0, 4'b1110, 4'b1101, 1'b0, 4'h2, 16'h0012};
      vecs[3] = '{1'b0, 4'b1110, 4'b1011, 1'b0, 4'h3, 16'h0123};
      vecs[4] = '{1'b0, 4'b1110, 4'b0111, 1'b0, 4'hA, 16'h123A};
      vecs[5] = '{1'b0, 4'b0111, 4'b1101, 1'b1, 4'hF, 16'h23AF};
      vecs[6] = '{1'b0, 4'b1011, 4'b0111, 1'b0, 4'hC, 16'h3AFC};
      vecs[7] = '{1'b0, 4'b0111, 4'b1110, 1'b0, 4'h0, 16'hAFC0};
      vecs[8] = '{1'b0, 4'b0111, 4'b0111, 1'b0, 4'hD, 16'hFC0D};

      doReset();
      checkResetState("reset");
      for (int k = 0; k < 64; k++) begin
         if (k > 0) @(negedge Clk);
         checkOutput($sformatf("idle_row_%0d", k), 16'(kif.Row), 16'(row_seq[(k / 4) % 4]));
      end
      checkOutput("idle_value", kif.Value, 16'h0000);

      for (int i = 0; i < 9; i++) applyStimulus(vecs[i]);

      // Two columns low on row 2 must be rejected while scanning carries on.
      press_row    = 4'b1011;
      press_cols   = 4'b1100;
      press_active = 1'b1;
      seen = 4'h0;
      for (int k = 0; k < 64; k++) begin
         @(negedge Clk);
         seen = seen | ~kif.Row;
      end
      press_active = 1'b0;
      checkOutput("ghost_rows_scanned", 16'(seen), 16'h000F);
      checkOutput("ghost_value", kif.Value, 16'hFC0D);
      checkOutput("ghost_keyheld", 16'(kif.KeyHeld), 16'd0);

      pressKey(4'b1011, 4'b1011, 1'b0, 4'h9, 16'hC0D9, found);
      repeat (3) @(negedge Clk);
      Rst          = 1'b1;
      press_active = 1'b0;
      @(negedge Clk);
      Rst = 1'b0;
      checkResetState("rst_mid_held");
      repeat (40) @(negedge Clk);

      applyStimulus('{1'b0, 4'b1011, 4'b1110, 1'b0, 4'h7, 16'h0007});
      found    = 1'b0;
      prev_row = kif.Row;
      for (int k = 0; k < 40 && !found; k++) begin
         @(negedge Clk);
         if (prev_row == 4'h7 && kif.Row == 4'hE) found = 1'b1;
         prev_row = kif.Row;
      end
      checkOutput("row_wrap_seen", 16'(found), 16'd1);
      // Row 0 has just begun its dwell, so the press is mid-debounce a few edges later.
      press_row    = 4'b1110;
      press_cols   = 4'b1110;
      press_active = 1'b1;
      repeat (7) @(negedge Clk);
      Rst          = 1'b1;
      press_active = 1'b0;
      @(negedge Clk);
      Rst = 1'b0;
      checkResetState("rst_mid_debounce");
      repeat (40) @(negedge Clk);
      applyStimulus('{1'b0, 4'b1110, 4'b1110, 1'b0, 4'h1, 16'h0001});

      repeat (8) @(negedge Clk);
      checkOutput("queue_drained", 16'(exp_q.size()), 16'd0);
      checkOutput("pulse_count", 16'(n_pulses), 16'(n_pushed));
      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 1000: number of Clk cycles each row stays driven during scanning; legal range 4 or more.
REQ-002 Parameter DEBOUNCE_CNT, default 20000: number of consecutive stable cycles required to accept a press or a release; legal range 2 or more.
REQ-003 Clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Rst  input  1  reset, synchronous and active-high.
REQ-005 Col  input  4  keypad column lines; active-low; asynchronous to Clk.
REQ-006 Row  output  4  keypad row drive; active-low one-cold; registered.
REQ-007 KeyCode  output  4  hex value of the last accepted key; registered.
REQ-008 KeyValid  output  1  single-cycle pulse when a key press is accepted.
REQ-009 KeyHeld  output  1  high from acceptance of a press until its release is accepted.
REQ-010 Value  output  16  hex-digit shift register, sized to feed one 4-digit display group.

Function
REQ-011 Col SHALL pass through a 2-flop synchronizer, giving ColS; all decisions use ColS only.
REQ-012 Key map, given as row r and column c (c = index of the low Col bit), SHALL be:
- r0: 1 2 3 A
- r1: 4 5 6 B
- r2: 7 8 9 C
- r3: 0 F E D
REQ-013 The FSM SHALL have exactly three states: SCAN, DEBOUNCE, HELD.
REQ-014 SCAN behaviour:
- Row drives index r low (r0 = 4'b1110, r3 = 4'b0111).
- A dwell counter counts 0..SCAN_DIV-1.
- On the last dwell cycle, ColS is sampled.
- The counter then wraps and r advances modulo 4 (r3 goes to r0).
REQ-015 If the SCAN sample has exactly one ColS bit low: capture r and c, clear the debounce counter, go to DEBOUNCE, and keep Row unchanged.
REQ-016 If the SCAN sample has zero or 2+ low ColS bits, no key is registered and scanning continues (ghost/multi-key rejection).
REQ-017 DEBOUNCE behaviour:
- Each cycle ColS equals the captured pattern, the counter increments.
- When a matching cycle occurs with the counter at DEBOUNCE_CNT-1, go to HELD.
- In that same edge, register KeyCode = map(r,c), KeyValid = 1, KeyHeld = 1, and Value = {Value[11:0], map(r,c)}.
REQ-018 Any mismatching ColS cycle in DEBOUNCE SHALL abort to SCAN: no output change, advance to row r+1, clear the dwell counter.
REQ-019 HELD behaviour:
- Row stays at r.
- The counter counts consecutive cycles with ColS == 4'b1111; any low bit clears it.
- At DEBOUNCE_CNT consecutive all-high cycles: KeyHeld becomes 0, go to SCAN at row r+1 with the dwell counter at 0.
REQ-020 KeyValid SHALL be high exactly one cycle per accepted press; holding a key SHALL NOT auto-repeat.
REQ-021 In HELD, changes in ColS other than all-high (pressing a second key, sliding to another column) SHALL be ignored.
REQ-022 Press latency: KeyValid rises at most 2 + 4·SCAN_DIV + DEBOUNCE_CNT cycles after a stable Col press.
REQ-023 KeyCode and Value SHALL hold between accepted presses.
REQ-024 Counters SHALL be wide enough for their parameters with no overflow; dwell wraps only as in REQ-014.

Reset
REQ-025 With Rst high at a Clk edge:
- Row = 4'b1110, KeyCode = 0, KeyValid = 0, KeyHeld = 0, Value = 16'h0000.
- State = SCAN, r = 0, both counters = 0.
- Synchronizer flops = 4'b1111.
REQ-026 Rst SHALL override every state, including mid-DEBOUNCE and mid-HELD; no KeyValid pulse may occur on or after the reset edge until a new full debounce completes.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=8)
REQ-027 Reset then idle, Col = 4'hF for 64 cycles:
- Row cycles E, D, B, 7, four cycles each.
- KeyValid never rises.
- Value stays 0000.
REQ-028 Press "5" (Col = 4'b1101 whenever Row = 4'b1101) and hold:
- One KeyValid pulse, KeyCode = 5, Value = 0005.
- KeyHeld stays 1 while held; Row frozen at 4'b1101.
REQ-029 Sequence 1, 2, 3, A, each with a clean release:
- Value = 123A.
- Exactly 4 KeyValid pulses.
- KeyHeld drops DEBOUNCE_CNT cycles (+2 sync) after each release.
REQ-030 Bounce press "F", Col toggling every 3 cycles for 20 cycles then stable:
- Exactly one KeyValid; KeyCode = F.
- No pulse during the bounce.
REQ-031 Two columns low on r2 (Col = 4'b1100):
- No capture, scanning continues, Value unchanged.
REQ-032 Rst asserted mid-DEBOUNCE and mid-HELD:
- Outputs return to REQ-025 values next edge.
- No KeyValid until a full re-press is debounced.
